dc_video_output_unit: RTL and testbench
=======================================

# dc_video_output_unit

Video output unit (VU) for the display controller. It consumes the IPU pixel stream (valid/ready plus border flag) and drives the raster timing and pixel outputs toward the HDMI/VGA encoder. It generates the horizontal and vertical counters, and returns `horizontal_blanking`/`vertical_blanking` to the main control logic. On a pixel underrun it blanks with a fixed colour, flags the fault, and resynchronises at the next vertical blank.

## Interface
Parameters:
- BITS_PER_PIXEL, 24, pixel width
- CNT_WIDTH, 12, width of the h/v counters
- H_ACTIVE / H_FP / H_SYNC / H_BP, 640 / 16 / 96 / 48, horizontal active pixels, front porch, sync, back porch
- V_ACTIVE / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 33, vertical equivalents in lines
- SYNC_ACTIVE_LOW, 1, sync pulse polarity (1 = pulse is 0)

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  counting enable
- pixel_valid  in  1  IPU pixel valid
- pixel_ready  out  1  VU accepts pixel
- pixel_data  in  BITS_PER_PIXEL  IPU pixel
- pixel_border  in  1  pixel is border fill (informational; passed to vid_border)
- underrun_color  in  BITS_PER_PIXEL  colour driven while not in RUN
- underrun_clr  in  1  clears the sticky underrun flag
- horizontal_blanking  out  1  h_cnt >= H_ACTIVE
- vertical_blanking  out  1  v_cnt >= V_ACTIVE
- vid_hsync, vid_vsync  out  1  sync pulses
- vid_de  out  1  data enable
- vid_data  out  BITS_PER_PIXEL  output pixel
- vid_border  out  1  registered pixel_border of accepted pixel
- frame_start  out  1  one-cycle pulse with first active pixel of frame
- underrun  out  1  sticky underrun flag

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. h_cnt counts 0..H_TOTAL-1. v_cnt increments when h_cnt wraps and itself wraps V_TOTAL-1 → 0.
- Counters advance only when en=1. When en=0 they hold.
- Reset state: h_cnt=0, v_cnt=V_ACTIVE (start of vertical blank), FSM=WAIT_FRAME. This guarantees a full blank before the first frame.
- active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- Blanking outputs are decoded combinationally from the counter registers.
- hsync is asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC. vsync uses the same rule on v_cnt.
- FSM states:
  - WAIT_FRAME → RUN when en && vertical_blanking.
  - RUN → RESYNC when en && active && !pixel_valid (underrun).
  - RESYNC → RUN when en && vertical_blanking.
  - Any state → WAIT_FRAME when en=0.
- pixel_ready = en && active && state==RUN && pixel_valid-independent. Ready never depends on valid.
- In RUN with a handshake: vid_data ← pixel_data, vid_border ← pixel_border.
- On an underrun cycle or in RESYNC/WAIT_FRAME during active: vid_data ← underrun_color, vid_border ← 0. In RESYNC pixel_ready=0, so the upstream stream is left untouched until it restarts on vertical_blanking.
- Outside active: vid_data ← 0.
- underrun is set on every RUN→RESYNC transition and cleared by underrun_clr. If set and clear occur in the same cycle, set wins.

## Timing
- All vid_* outputs and frame_start are registered, 1 cycle after the counter value that produced them. hsync, vsync, de and data stay mutually aligned.
- pixel_ready is combinational from registered state and en only. A pixel accepted at cycle n appears on vid_data at n+1.
- frame_start=1 in the cycle where vid_de is set for h=0, v=0 and state==RUN.
- With en=0: vid_de=0 on the next edge. Syncs hold their last value, and counters hold.
- Reset values: vid_hsync=vid_vsync=SYNC_ACTIVE_LOW (inactive level), vid_de=0, vid_data=0, vid_border=0, frame_start=0, underrun=0.
- Blanking outputs after reset: horizontal_blanking=0, vertical_blanking=1.
- Reset asserted mid-frame returns all of the above immediately (async) and discards any in-flight pixel.

## Test plan
Small configuration for all scenarios: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1, giving H_TOTAL=8 and V_TOTAL=6.

- **Reset, en=1, source always valid:**
  - First pixel_ready occurs 24 cycles after rst falls.
  - frame_start pulses 1 cycle later.
  - Exactly 12 pixels are accepted per 48-cycle frame.
- **Sync shape:**
  - vid_hsync is low for 2 cycles starting 5 cycles after each line's first vid_de.
  - vid_vsync is low for 8 cycles, 1 line after the last active line.
- **Data path:** feed incrementing pixels 1..12 → vid_data shows 1..12 in raster order, each 1 cycle after its handshake, with vid_de high only on those cycles.
- **Underrun:** drop pixel_valid on pixel 6 →
  - vid_data = underrun_color for pixels 6..12.
  - underrun=1, pixel_ready=0 until the next vertical blank.
  - The next frame shows correct data.
  - underrun_clr coinciding with a new underrun leaves underrun=1.
- **en toggling:** drop en for 5 cycles mid-line → counters freeze, vid_de=0, no pixels accepted. The FSM waits for vertical blank before accepting pixels again.
- **Async reset mid-frame:** assert rst mid-frame → all outputs take their reset values without waiting for a clk edge.

Source files
------------

// File: rtl/dc_video_output_unit.sv
`default_nettype none
// ============================================================================
// Module   : dc_video_output_unit
// Purpose  : Video output unit of the display controller. Generates the raster
//            (h/v counters, blanking, sync), consumes the IPU pixel stream
//            through a valid/ready handshake and drives registered pixel and
//            timing outputs toward the HDMI/VGA encoder. On a pixel underrun
//            the unit fills with a fixed colour, raises a sticky fault flag and
//            only resumes pulling pixels at the next vertical blank.
//
// Ports    : clk, rst               - clock, asynchronous active-high reset
//            en                     - counting enable (0 freezes the raster)
//            pixel_valid/_ready     - IPU stream handshake
//            pixel_data/_border     - IPU pixel and its border-fill tag
//            underrun_color         - fill colour while not streaming
//            underrun_clr           - clears the sticky underrun flag
//            horizontal_blanking    - h counter outside active area
//            vertical_blanking      - v counter outside active area
//            vid_hsync/vid_vsync    - registered sync pulses
//            vid_de/vid_data        - registered data enable and pixel
//            vid_border             - registered border tag of accepted pixel
//            frame_start            - pulse with first active pixel of a frame
//            underrun               - sticky underrun flag
//
// Revision : 1.0 - initial release
// ============================================================================
module dc_video_output_unit #(
    parameter int BITS_PER_PIXEL  = 24,
    parameter int CNT_WIDTH       = 12,
    parameter int H_ACTIVE        = 640,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      pixel_valid,
    output logic                      pixel_ready,
    input  logic [BITS_PER_PIXEL-1:0] pixel_data,
    input  logic                      pixel_border,
    input  logic [BITS_PER_PIXEL-1:0] underrun_color,
    input  logic                      underrun_clr,
    output logic                      horizontal_blanking,
    output logic                      vertical_blanking,
    output logic                      vid_hsync,
    output logic                      vid_vsync,
    output logic                      vid_de,
    output logic [BITS_PER_PIXEL-1:0] vid_data,
    output logic                      vid_border,
    output logic                      frame_start,
    output logic                      underrun
);

    // ------------------------------------------------------------------------
    // Raster geometry
    // ------------------------------------------------------------------------
    localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_WIDTH-1:0] c_h_active   = CNT_WIDTH'(H_ACTIVE);
    localparam logic [CNT_WIDTH-1:0] c_h_last     = CNT_WIDTH'(c_h_total - 1);
    localparam logic [CNT_WIDTH-1:0] c_hs_start   = CNT_WIDTH'(H_ACTIVE + H_FP);
    localparam logic [CNT_WIDTH-1:0] c_hs_end     = CNT_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_WIDTH-1:0] c_v_active   = CNT_WIDTH'(V_ACTIVE);
    localparam logic [CNT_WIDTH-1:0] c_v_last     = CNT_WIDTH'(c_v_total - 1);
    localparam logic [CNT_WIDTH-1:0] c_vs_start   = CNT_WIDTH'(V_ACTIVE + V_FP);
    localparam logic [CNT_WIDTH-1:0] c_vs_end     = CNT_WIDTH'(V_ACTIVE + V_FP + V_SYNC);

    // ------------------------------------------------------------------------
    // Stream state machine encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_st_wait_frame = 2'd0;
    localparam logic [1:0] c_st_run        = 2'd1;
    localparam logic [1:0] c_st_resync     = 2'd2;

    logic [CNT_WIDTH-1:0] r_h_cnt;
    logic [CNT_WIDTH-1:0] r_v_cnt;
    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;

    logic w_active;
    logic w_h_pulse;
    logic w_v_pulse;
    logic w_take;
    logic w_fault;

    // ------------------------------------------------------------------------
    // Raster counters. Reset parks v at the first blank line so a complete
    // vertical blank always precedes the first displayed frame.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= c_v_active;
        end else if (en) begin
            if (r_h_cnt == c_h_last) begin
                r_h_cnt <= '0;
                if (r_v_cnt == c_v_last) begin
                    r_v_cnt <= '0;
                end else begin
                    r_v_cnt <= r_v_cnt + 1'b1;
                end
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Combinational raster decode
    // ------------------------------------------------------------------------
    assign horizontal_blanking = (r_h_cnt >= c_h_active);
    assign vertical_blanking   = (r_v_cnt >= c_v_active);
    assign w_active            = !horizontal_blanking && !vertical_blanking;
    assign w_h_pulse           = (r_h_cnt >= c_hs_start) && (r_h_cnt < c_hs_end);
    assign w_v_pulse           = (r_v_cnt >= c_vs_start) && (r_v_cnt < c_vs_end);

    // Ready is a function of registered state and en only, never of valid.
    assign pixel_ready = en && w_active && (r_state == c_st_run);
    assign w_take      = pixel_ready && pixel_valid;
    // A slot the stream was supposed to fill but could not.
    assign w_fault     = pixel_ready && !pixel_valid;

    // ------------------------------------------------------------------------
    // Stream state machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_wait_frame;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!en) begin
            w_state_nxt = c_st_wait_frame;
        end else begin
            case (r_state)
                c_st_wait_frame: if (vertical_blanking) w_state_nxt = c_st_run;
                c_st_run:        if (w_fault)           w_state_nxt = c_st_resync;
                c_st_resync:     if (vertical_blanking) w_state_nxt = c_st_run;
                default:         w_state_nxt = c_st_wait_frame;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Registered video outputs: all aligned one cycle behind the counters.
    // While disabled, syncs keep their level and the data path goes quiet.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vid_hsync   <= SYNC_ACTIVE_LOW;
            vid_vsync   <= SYNC_ACTIVE_LOW;
            vid_de      <= 1'b0;
            vid_data    <= '0;
            vid_border  <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            vid_hsync   <= w_h_pulse ? ~SYNC_ACTIVE_LOW : SYNC_ACTIVE_LOW;
            vid_vsync   <= w_v_pulse ? ~SYNC_ACTIVE_LOW : SYNC_ACTIVE_LOW;
            vid_de      <= w_active;
            vid_border  <= w_take && pixel_border;
            frame_start <= w_active && (r_h_cnt == '0) && (r_v_cnt == '0)
                           && (r_state == c_st_run);
            if (w_take) begin
                vid_data <= pixel_data;
            end else if (w_active) begin
                vid_data <= underrun_color;
            end else begin
                vid_data <= '0;
            end
        end else begin
            vid_de      <= 1'b0;
            vid_data    <= '0;
            vid_border  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Sticky underrun flag; a new fault outranks a simultaneous clear.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun <= 1'b0;
        end else if (w_fault) begin
            underrun <= 1'b1;
        end else if (underrun_clr) begin
            underrun <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dc_video_output_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_dc_video_output_unit
// Purpose  : Self-checking bench for dc_video_output_unit in a small 8x6
//            raster. A frame-position reference model (position in frame plus
//            a "stream locked" bit) predicts every output each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dc_video_output_unit;

    localparam int BPP    = 24;
    localparam int H_ACT  = 4;
    localparam int HFP    = 1;
    localparam int HSY    = 2;
    localparam int HBP    = 1;
    localparam int V_ACT  = 3;
    localparam int VFP    = 1;
    localparam int VSY    = 1;
    localparam int VBP    = 1;
    localparam int HT     = H_ACT + HFP + HSY + HBP;
    localparam int VT     = V_ACT + VFP + VSY + VBP;
    localparam int FRAME  = HT * VT;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic           pixel_valid;
    logic           pixel_ready;
    logic [BPP-1:0] pixel_data;
    logic           pixel_border;
    logic [BPP-1:0] underrun_color;
    logic           underrun_clr;
    logic           horizontal_blanking;
    logic           vertical_blanking;
    logic           vid_hsync;
    logic           vid_vsync;
    logic           vid_de;
    logic [BPP-1:0] vid_data;
    logic           vid_border;
    logic           frame_start;
    logic           underrun;

    dc_video_output_unit #(
        .BITS_PER_PIXEL (BPP),
        .CNT_WIDTH      (12),
        .H_ACTIVE       (H_ACT),
        .H_FP           (HFP),
        .H_SYNC         (HSY),
        .H_BP           (HBP),
        .V_ACTIVE       (V_ACT),
        .V_FP           (VFP),
        .V_SYNC         (VSY),
        .V_BP           (VBP),
        .SYNC_ACTIVE_LOW(1'b1)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .en                 (en),
        .pixel_valid        (pixel_valid),
        .pixel_ready        (pixel_ready),
        .pixel_data         (pixel_data),
        .pixel_border       (pixel_border),
        .underrun_color     (underrun_color),
        .underrun_clr       (underrun_clr),
        .horizontal_blanking(horizontal_blanking),
        .vertical_blanking  (vertical_blanking),
        .vid_hsync          (vid_hsync),
        .vid_vsync          (vid_vsync),
        .vid_de             (vid_de),
        .vid_data           (vid_data),
        .vid_border         (vid_border),
        .frame_start        (frame_start),
        .underrun           (underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: position within the frame and whether the stream is
    // currently being pulled (locked). Lock is gained in vertical blank and
    // lost on a missed pixel or when disabled.
    int             m_pos;
    bit             m_locked;
    logic           m_de, m_hs, m_vs, m_border, m_fs, m_uflag;
    logic [BPP-1:0] m_data;

    // Per-cycle observations: {ready, hblank, vblank} before the edge and
    // {de, hsync, vsync, border, frame_start, underrun, data} after it.
    logic [2:0]  cmb_obs, cmb_exp;
    logic [29:0] reg_obs, reg_exp;

    task automatic model_reset();
        m_pos    = V_ACT * HT;
        m_locked = 1'b0;
        m_de     = 1'b0;
        m_hs     = 1'b1;
        m_vs     = 1'b1;
        m_border = 1'b0;
        m_fs     = 1'b0;
        m_uflag  = 1'b0;
        m_data   = '0;
    endtask

    task automatic drive(input bit e, input bit vld, input bit clr);
        en           = e;
        pixel_valid  = vld;
        underrun_clr = clr;
        pixel_data   = BPP'($urandom);
        pixel_border = 1'($urandom);
    endtask

    // Called at a falling edge with inputs already driven; returns at the
    // next falling edge with observations and predictions captured.
    task automatic step();
        int h, v;
        bit act, rdy, took, fault;
        #1;
        h     = m_pos % HT;
        v     = m_pos / HT;
        act   = (h < H_ACT) && (v < V_ACT);
        rdy   = en && act && m_locked;
        took  = rdy && pixel_valid;
        fault = rdy && !pixel_valid;
        cmb_exp = {rdy, (h >= H_ACT), (v >= V_ACT)};
        cmb_obs = {pixel_ready, horizontal_blanking, vertical_blanking};
        if (en) begin
            m_de     = act;
            m_hs     = !((h >= H_ACT + HFP) && (h < H_ACT + HFP + HSY));
            m_vs     = !((v >= V_ACT + VFP) && (v < V_ACT + VFP + VSY));
            m_border = took && pixel_border;
            m_fs     = act && (m_pos == 0) && m_locked;
            if (took)     m_data = pixel_data;
            else if (act) m_data = underrun_color;
            else          m_data = '0;
            if (v >= V_ACT)  m_locked = 1'b1;
            else if (fault)  m_locked = 1'b0;
            m_pos = (m_pos + 1) % FRAME;
        end else begin
            m_de     = 1'b0;
            m_border = 1'b0;
            m_fs     = 1'b0;
            m_data   = '0;
            m_locked = 1'b0;
        end
        if (fault)             m_uflag = 1'b1;
        else if (underrun_clr) m_uflag = 1'b0;
        reg_exp = {m_de, m_hs, m_vs, m_border, m_fs, m_uflag, m_data};
        @(posedge clk);
        @(negedge clk);
        reg_obs = {vid_de, vid_hsync, vid_vsync, vid_border, frame_start, underrun, vid_data};
    endtask

    // Steps with a valid source until the model sits at the given position.
    task automatic align(input int target);
        int n = 0;
        while (m_pos != target && n < 3 * FRAME) begin
            drive(1'b1, 1'b1, 1'b0);
            step();
            if ({cmb_obs, reg_obs} !== {cmb_exp, reg_exp}) begin
                errors++;
                $display("FAIL align_model n=%0d: got %h expected %h", n, {cmb_obs, reg_obs}, {cmb_exp, reg_exp});
            end
            checks++;
            n++;
        end
        if (n >= 3 * FRAME) begin
            errors++;
            $display("FAIL align_timeout: position %0d not reached", target);
        end
    endtask

    task automatic test_reset();
        logic [32:0] rst_obs;
        logic [32:0] rst_exp;
        int first_rdy = -1;
        int fs_at     = -1;
        int accepted  = 0;
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0);
        underrun_color = BPP'($urandom);
        repeat (2) @(negedge clk);
        rst_exp = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 1'b1};
        rst_obs = {vid_de, vid_hsync, vid_vsync, vid_border, frame_start, underrun, vid_data,
                   pixel_ready, horizontal_blanking, vertical_blanking};
        checks++;
        if (rst_obs !== rst_exp) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h", rst_obs, rst_exp);
        end
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 72; k++) begin
            drive(1'b1, 1'b1, 1'b0);
            step();
            checks++;
            if ({cmb_obs, reg_obs} !== {cmb_exp, reg_exp}) begin
                errors++;
                $display("FAIL reset_model k=%0d: got %h expected %h", k, {cmb_obs, reg_obs}, {cmb_exp, reg_exp});
            end
            if (cmb_obs[2] && first_rdy < 0) first_rdy = k;
            if (reg_obs[25] && fs_at < 0)    fs_at = k;
            if (k >= 24 && cmb_obs[2])       accepted++;
        end
        checks++;
        if (first_rdy !== 24) begin
            errors++;
            $display("FAIL first_ready: cycle %0d, required 24", first_rdy);
        end
        checks++;
        if (fs_at !== 24) begin
            errors++;
            $display("FAIL frame_start_timing: seen after edge %0d, required 24", fs_at);
        end
        checks++;
        if (accepted !== 12) begin
            errors++;
            $display("FAIL pixels_per_frame: got %0d, required 12", accepted);
        end
    endtask

    task automatic test_sync_shape();
        int de_rise[$];
        int hs_fall[$];
        int vs_fall = -1;
        int hs_low = 0;
        int vs_low = 0;
        logic p_de = 1'b0;
        logic p_hs = 1'b1;
        logic p_vs = 1'b1;
        align(0);
        for (int t = 0; t < FRAME; t++) begin
            drive(1'b1, 1'b1, 1'b0);
            step();
            checks++;
            if ({cmb_obs, reg_obs} !== {cmb_exp, reg_exp}) begin
                errors++;
                $display("FAIL sync_model t=%0d: got %h expected %h", t, {cmb_obs, reg_obs}, {cmb_exp, reg_exp});
            end
            if (reg_obs[29] && !p_de)              de_rise.push_back(t);
            if (!reg_obs[28] && p_hs)              hs_fall.push_back(t);
            if (!reg_obs[27] && p_vs && vs_fall < 0) vs_fall = t;
            if (!reg_obs[28]) hs_low++;
            if (!reg_obs[27]) vs_low++;
            p_de = reg_obs[29];
            p_hs = reg_obs[28];
            p_vs = reg_obs[27];
        end
        checks++;
        if (de_rise.size() != V_ACT || hs_fall.size() != VT) begin
            errors++;
            $display("FAIL sync_edges: de lines %0d hsync pulses %0d, required %0d and %0d",
                     de_rise.size(), hs_fall.size(), V_ACT, VT);
        end else begin
            for (int i = 0; i < V_ACT; i++) begin
                checks++;
                if (hs_fall[i] - de_rise[i] != 5) begin
                    errors++;
                    $display("FAIL hsync_offset line %0d: got %0d, required 5", i, hs_fall[i] - de_rise[i]);
                end
            end
            checks++;
            if (vs_fall - de_rise[V_ACT-1] != 2 * HT) begin
                errors++;
                $display("FAIL vsync_offset: got %0d, required %0d", vs_fall - de_rise[V_ACT-1], 2 * HT);
            end
        end
        checks++;
        if (hs_low != 2 * VT) begin
            errors++;
            $display("FAIL hsync_width: low %0d cycles, required %0d", hs_low, 2 * VT);
        end
        checks++;
        if (vs_low != 8) begin
            errors++;
            $display("FAIL vsync_width: low %0d cycles, required 8", vs_low);
        end
    endtask

    task automatic test_data_path();
        int nxt = 1;
        int seq = 1;
        align(0);
        for (int t = 0; t < FRAME; t++) begin
            drive(1'b1, 1'b1, 1'b0);
            pixel_data = BPP'(nxt);
            step();
            if (cmb_obs[2]) nxt++;
            checks++;
            if ({cmb_obs, reg_obs} !== {cmb_exp, reg_exp}) begin
                errors++;
                $display("FAIL data_model t=%0d: got %h expected %h", t, {cmb_obs, reg_obs}, {cmb_exp, reg_exp});
            end
            if (reg_obs[29]) begin
                checks++;
                if (reg_obs[23:0] !== BPP'(seq)) begin
                    errors++;
                    $display("FAIL data_order t=%0d: got %0d, required %0d", t, reg_obs[23:0], seq);
                end
                seq++;
            end
        end
        checks++;
        if (seq != 13 || nxt != 13) begin
            errors++;
            $display("FAIL data_count: shown %0d accepted %0d, required 12 and 12", seq - 1, nxt - 1);
        end
    endtask

    task automatic test_underrun();
        int  n;
        int  acc = 0;
        bit  act;
        underrun_color = BPP'($urandom);
        align(0);
        for (int t = 0; t < FRAME; t++) begin
            act = ((t % HT) < H_ACT) && ((t / HT) < V_ACT);
            n   = (t / HT) * H_ACT + (t % HT) + 1;
            drive(1'b1, !(act && n == 6), 1'b0);
            step();
            checks++;
            if ({cmb_obs, reg_obs} !== {cmb_exp, reg_exp}) begin
                errors++;
                $display("FAIL underrun_model t=%0d: got %h expected %h", t, {cmb_obs, reg_obs}, {cmb_exp, reg_exp});
            end
            if (act && n >= 6) begin
                checks++;
                if ({reg_obs[29], reg_obs[24], reg_obs[23:0]} !== {1'b1, 1'b1, underrun_color}) begin
                    errors++;
                    $display("FAIL underrun_fill pixel %0d: de/flag/data %h, required %h", n,
                             {reg_obs[29], reg_obs[24], reg_obs[23:0]}, {1'b1, 1'b1, underrun_color});
                end
            end
            if (act && n > 6) begin
                checks++;
                if (cmb_obs[2] !== 1'b0) begin
                    errors++;
                    $display("FAIL underrun_ready pixel %0d: ready %b, required 0", n, cmb_obs[2]);
                end
            end
        end
        // Following frame: fully recovered; flag cleared in the blank.
        for (int t = 0; t < FRAME; t++) begin
            drive(1'b1, 1'b1, (t == 40));
            step();
            if (cmb_obs[2]) acc++;
            checks++;
            if ({cmb_obs, reg_obs} !== {cmb_exp, reg_exp}) begin
                errors++;
                $display("FAIL recover_model t=%0d: got %h expected %h", t, {cmb_obs, reg_obs}, {cmb_exp, reg_exp});
            end
            if (t == 40) begin
                checks++;
                if (reg_obs[24] !== 1'b0) begin
                    errors++;
                    $display("FAIL underrun_clear: flag %b, required 0", reg_obs[24]);
                end
            end
        end
        checks++;
        if (acc != 12) begin
            errors++;
            $display("FAIL recover_count: accepted %0d, required 12", acc);
        end
        // Clear and new underrun in the same cycle: the set must win.
        drive(1'b1, 1'b0, 1'b1);
        step();
        checks++;
        if ({cmb_obs[2], reg_obs[24]} !== 2'b11) begin
            errors++;
            $display("FAIL set_beats_clear: ready/flag %b, required 11", {cmb_obs[2], reg_obs[24]});
        end
        align(0);
    endtask

    task automatic test_en_toggle();
        int acc = 0;
        int n   = 0;
        align(1);
        for (int t = 0; t < 5; t++) begin
            drive(1'b0, 1'b1, 1'b0);
            step();
            checks++;
            if ({cmb_obs, reg_obs} !== {cmb_exp, reg_exp} || cmb_obs[2] !== 1'b0 || reg_obs[29] !== 1'b0) begin
                errors++;
                $display("FAIL en_off t=%0d: got %h expected %h", t, {cmb_obs, reg_obs}, {cmb_exp, reg_exp});
            end
        end
        while (m_pos != V_ACT * HT && n < FRAME) begin
            drive(1'b1, 1'b1, 1'b0);
            step();
            if (cmb_obs[2]) acc++;
            checks++;
            if ({cmb_obs, reg_obs} !== {cmb_exp, reg_exp}) begin
                errors++;
                $display("FAIL en_wait_model n=%0d: got %h expected %h", n, {cmb_obs, reg_obs}, {cmb_exp, reg_exp});
            end
            n++;
        end
        checks++;
        if (acc != 0 || n >= FRAME) begin
            errors++;
            $display("FAIL en_wait_blank: accepted %0d before blank (steps %0d), required 0", acc, n);
        end
        acc = 0;
        for (int t = 0; t < FRAME; t++) begin
            drive(1'b1, 1'b1, 1'b0);
            step();
            if (cmb_obs[2]) acc++;
            checks++;
            if ({cmb_obs, reg_obs} !== {cmb_exp, reg_exp}) begin
                errors++;
                $display("FAIL en_resume_model t=%0d: got %h expected %h", t, {cmb_obs, reg_obs}, {cmb_exp, reg_exp});
            end
        end
        checks++;
        if (acc != 12) begin
            errors++;
            $display("FAIL en_resume_count: accepted %0d, required 12", acc);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 400; t++) begin
            drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 31) == 0) underrun_color = BPP'($urandom);
            step();
            checks++;
            if ({cmb_obs, reg_obs} !== {cmb_exp, reg_exp}) begin
                errors++;
                $display("FAIL random_model t=%0d: got %h expected %h", t, {cmb_obs, reg_obs}, {cmb_exp, reg_exp});
            end
        end
    endtask

    task automatic test_async_reset();
        logic [32:0] rst_obs;
        logic [32:0] rst_exp;
        align(0);
        align(0);
        drive(1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b0);
        step();
        checks++;
        if ({reg_obs[29], reg_obs[24]} !== 2'b11) begin
            errors++;
            $display("FAIL pre_reset_state: de/flag %b, required 11", {reg_obs[29], reg_obs[24]});
        end
        #2;
        rst = 1'b1;
        #1;
        rst_exp = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 1'b1};
        rst_obs = {vid_de, vid_hsync, vid_vsync, vid_border, frame_start, underrun, vid_data,
                   pixel_ready, horizontal_blanking, vertical_blanking};
        checks++;
        if (rst_obs !== rst_exp) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", rst_obs, rst_exp);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int t = 0; t < 30; t++) begin
            drive(1'b1, 1'b1, 1'b0);
            step();
            checks++;
            if ({cmb_obs, reg_obs} !== {cmb_exp, reg_exp}) begin
                errors++;
                $display("FAIL post_reset_model t=%0d: got %h expected %h", t, {cmb_obs, reg_obs}, {cmb_exp, reg_exp});
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        en             = 1'b0;
        pixel_valid    = 1'b0;
        pixel_data     = '0;
        pixel_border   = 1'b0;
        underrun_color = '0;
        underrun_clr   = 1'b0;
        model_reset();
        test_reset();
        test_sync_shape();
        test_data_path();
        test_underrun();
        test_en_toggle();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
